// File: rtl/lcd_pixel_capture_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pixel_capture_pkg
//   Shared constants, types and helpers for the LT24 pixel-capture block:
//   panel geometry, field widths, common RGB565 colours, the capture FSM
//   state encoding and the pixel-to-linear-address mapping.
// ---------------------------------------------------------------------------
package lcd_pixel_capture_pkg;

    localparam int unsigned LCD_WIDTH  = 240;
    localparam int unsigned LCD_HEIGHT = 320;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned DATA_W = 16;
    // 240 * 320 = 76800 < 2^17, so a 17-bit linear address covers the panel.
    localparam int unsigned ADDR_W = 17;

    typedef logic [X_W-1:0]    x_coord_t;
    typedef logic [Y_W-1:0]    y_coord_t;
    typedef logic [DATA_W-1:0] rgb565_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    localparam rgb565_t RGB565_BLACK = 16'h0000;
    localparam rgb565_t RGB565_RED   = 16'hF800;
    localparam rgb565_t RGB565_GREEN = 16'h07E0;
    localparam rgb565_t RGB565_BLUE  = 16'h001F;
    localparam rgb565_t RGB565_WHITE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WRITE,
        ST_HOLD,
        ST_CLEAR
    } cap_state_e;

    // Row-major linear address, truncated to the framebuffer address width.
    function automatic fb_addr_t pixel_addr(input x_coord_t x, input y_coord_t y,
                                            input int unsigned w);
        logic [31:0] full;
        full = 32'(y) * w + 32'(x);
        return full[ADDR_W-1:0];
    endfunction

    function automatic logic in_bounds(input x_coord_t x, input y_coord_t y,
                                       input int unsigned w, input int unsigned h);
        return (32'(x) < w) && (32'(y) < h);
    endfunction

endpackage

// File: rtl/lcd_pixel_capture_if.sv
// ---------------------------------------------------------------------------
// lcd_pixel_capture_if
//   LT24 pixel-write handshake plus framebuffer readback port.
//   master : drawer side   (drives xAddr/yAddr/pixelData/pixelWrite, rdReq/rdX/rdY)
//   slave  : capture side  (drives pixelReady, rdData/rdValid)
// ---------------------------------------------------------------------------
interface lcd_pixel_capture_if;
    import lcd_pixel_capture_pkg::*;

    x_coord_t xAddr;
    y_coord_t yAddr;
    rgb565_t  pixelData;
    logic     pixelWrite;
    logic     pixelReady;

    logic     rdReq;
    x_coord_t rdX;
    y_coord_t rdY;
    rgb565_t  rdData;
    logic     rdValid;

    modport master (
        output xAddr, yAddr, pixelData, pixelWrite, rdReq, rdX, rdY,
        input  pixelReady, rdData, rdValid
    );

    modport slave (
        input  xAddr, yAddr, pixelData, pixelWrite, rdReq, rdX, rdY,
        output pixelReady, rdData, rdValid
    );

endinterface

// File: rtl/lcd_pixel_capture_ram.sv
// ---------------------------------------------------------------------------
// capture_ram
//   Simple dual-port framebuffer RAM, 2^ADDR_W x DATA_W, single clock.
//   clock       : clock
//   we/waddr/wdata : write port
//   raddr/rdata : registered read port, returns old data on a same-address
//                 write in the same cycle
// ---------------------------------------------------------------------------
module capture_ram #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // NOTE: the array has no reset; a reset port would stop block-RAM
    // inference, and framebuffer contents are meant to survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lcd_pixel_capture.sv
// ---------------------------------------------------------------------------
// lcd_pixel_capture
//   Responder end of the LT24 pixel-write handshake. Accepted pixels are
//   stored in an on-chip framebuffer that can be read back independently.
//   clock, reset : system clock, asynchronous active-high reset
//   pix          : pixel handshake + readback port (slave modport)
//   clearReq     : one-cycle pulse, fill framebuffer with CLEAR_COLOUR (IDLE only)
//   pixelCount   : in-range pixels written since reset/clear, saturating
//   clipError    : sticky flag, an out-of-range pixel was presented
// ---------------------------------------------------------------------------
module lcd_pixel_capture
    import lcd_pixel_capture_pkg::*;
#(
    parameter int unsigned WIDTH         = LCD_WIDTH,
    parameter int unsigned HEIGHT        = LCD_HEIGHT,
    parameter int unsigned WRITE_LATENCY = 4,         // 3..258
    parameter rgb565_t     CLEAR_COLOUR  = RGB565_BLACK
) (
    input  logic                 clock,
    input  logic                 reset,
    lcd_pixel_capture_if.slave   pix,
    input  logic                 clearReq,
    output logic [23:0]          pixelCount,
    output logic                 clipError
);

    localparam int unsigned HOLD_W    = 8;
    // ADDR, WRITE and the final HOLD cycle account for three cycles of latency.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(WRITE_LATENCY - 3);
    localparam fb_addr_t          LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    cap_state_e state, state_next;

    logic             ready_q, ready_next;
    logic             armed;
    logic             accept, clear_start;
    x_coord_t         x_q;
    y_coord_t         y_q;
    rgb565_t          data_q;
    fb_addr_t         addr_q;
    logic             in_range_q;
    logic [HOLD_W-1:0] hold_q;
    fb_addr_t         clr_addr_q;

    // Write port request from the FSM, and its registered copy feeding the RAM.
    logic     ram_we;
    fb_addr_t ram_waddr;
    rgb565_t  ram_wdata;
    logic     ram_we_q;
    fb_addr_t ram_waddr_q;
    rgb565_t  ram_wdata_q;

    // Readback pipeline
    logic     rd_v1, rd_v2;
    logic     rd_in1, rd_in2;
    fb_addr_t rd_addr_q;
    rgb565_t  ram_rdata;
    rgb565_t  rd_data_q;
    logic     rd_valid_q;

    assign pix.pixelReady = ready_q;
    assign pix.rdData     = rd_data_q;
    assign pix.rdValid    = rd_valid_q;

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        ready_next  = 1'b0;
        accept      = 1'b0;
        clear_start = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = addr_q;
        ram_wdata   = data_q;

        unique case (state)
            ST_IDLE: begin
                ready_next = 1'b1;
                // A clear takes priority over a pixel presented in the same cycle.
                if (clearReq) begin
                    clear_start = 1'b1;
                    ready_next  = 1'b0;
                    state_next  = ST_CLEAR;
                end else if (pix.pixelWrite && armed) begin
                    accept     = 1'b1;
                    ready_next = 1'b0;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                ram_we     = in_range_q;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    ready_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = CLEAR_COLOUR;
                if (clr_addr_q == LAST_ADDR) begin
                    ready_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and write-path datapath
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b0;
            armed       <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            in_range_q  <= 1'b0;
            hold_q      <= '0;
            clr_addr_q  <= '0;
            pixelCount  <= '0;
            clipError   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            state   <= state_next;
            ready_q <= ready_next;

            // One assertion of pixelWrite buys one pixel: re-arm only once
            // the initiator has been seen to drop the request.
            if (!pix.pixelWrite) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end

            if (accept) begin
                x_q    <= pix.xAddr;
                y_q    <= pix.yAddr;
                data_q <= pix.pixelData;
            end

            if (state == ST_ADDR) begin
                addr_q     <= pixel_addr(x_q, y_q, WIDTH);
                in_range_q <= in_bounds(x_q, y_q, WIDTH, HEIGHT);
            end

            if (state == ST_WRITE) begin
                hold_q <= HOLD_LOAD;
                if (in_range_q) begin
                    if (pixelCount != '1) begin
                        pixelCount <= pixelCount + 24'd1;
                    end
                end else begin
                    clipError <= 1'b1;
                end
            end else if ((state == ST_HOLD) && (hold_q != '0)) begin
                hold_q <= hold_q - 8'd1;
            end

            if (clear_start) begin
                clr_addr_q <= '0;
                pixelCount <= '0;
                clipError  <= 1'b0;
            end else if (state == ST_CLEAR) begin
                clr_addr_q <= clr_addr_q + 17'd1;
            end

            // The RAM commits one cycle after the FSM requests the write, so
            // a reset landing in HOLD still drops the pending pixel.
            ram_we_q <= ram_we;
            if (ram_we) begin
                ram_waddr_q <= ram_waddr;
                ram_wdata_q <= ram_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Readback: request edge n -> address reg at n, RAM read at n+1,
    // output register at n+2. Independent of the write FSM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_v1      <= 1'b0;
            rd_v2      <= 1'b0;
            rd_in1     <= 1'b0;
            rd_in2     <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_v1  <= pix.rdReq;
            rd_in1 <= in_bounds(pix.rdX, pix.rdY, WIDTH, HEIGHT);
            if (pix.rdReq) begin
                rd_addr_q <= pixel_addr(pix.rdX, pix.rdY, WIDTH);
            end
            rd_v2      <= rd_v1;
            rd_in2     <= rd_in1;
            rd_valid_q <= rd_v2;
            if (rd_v2) begin
                rd_data_q <= rd_in2 ? ram_rdata : '0;
            end
        end
    end

    capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_q),
        .waddr (ram_waddr_q),
        .wdata (ram_wdata_q),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_lcd_pixel_capture.sv
// ---------------------------------------------------------------------------
// tb_lcd_pixel_capture
//   Self-checking bench for lcd_pixel_capture. A framebuffer model (associative
//   array keyed by linear address) plus expected counter/flag values track what
//   the panel should hold; drawers follow the LT24 DrawMif-style handshake.
// ---------------------------------------------------------------------------
module tb_lcd_pixel_capture;
    import lcd_pixel_capture_pkg::*;

    localparam int W = 240;
    localparam int H = 320;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clearReq;
    logic [23:0] pixelCount;
    logic        clipError;

    lcd_pixel_capture_if pix ();

    lcd_pixel_capture dut (
        .clock      (clock),
        .reset      (reset),
        .pix        (pix),
        .clearReq   (clearReq),
        .pixelCount (pixelCount),
        .clipError  (clipError)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model
    rgb565_t fb [int];
    int      exp_count = 0;
    logic    exp_clip  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rgb565_t model_rd(input int x, input int y);
        if (x >= W || y >= H) return 16'h0000;
        if (fb.exists(y * W + x)) return fb[y * W + x];
        return 16'h0000;
    endfunction

    function automatic void model_write(input int x, input int y, input rgb565_t d);
        if (x < W && y < H) begin
            fb[y * W + x] = d;
            if (exp_count < 24'hFFFFFF) exp_count++;
        end else begin
            exp_clip = 1'b1;
        end
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!pix.pixelReady && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check(tag, pix.pixelReady, 1);
    endtask

    // Present one pixel; hold_extra > 0 keeps pixelWrite high until pixelReady
    // returns and then for hold_extra more cycles. Returns cycles spent low.
    task automatic draw(input int x, input int y, input rgb565_t d,
                        input int hold_extra, output int low);
        wait_ready("draw_wait");
        pix.xAddr      = x_coord_t'(x);
        pix.yAddr      = y_coord_t'(y);
        pix.pixelData  = d;
        pix.pixelWrite = 1'b1;
        @(negedge clock);
        if (hold_extra == 0) pix.pixelWrite = 1'b0;
        low = 0;
        while (!pix.pixelReady && low < 100000) begin
            low++;
            @(negedge clock);
        end
        if (hold_extra > 0) begin
            repeat (hold_extra) @(negedge clock);
            pix.pixelWrite = 1'b0;
        end
        model_write(x, y, d);
    endtask

    task automatic check_rd(input string tag, input int x, input int y);
        pix.rdX   = x_coord_t'(x);
        pix.rdY   = y_coord_t'(y);
        pix.rdReq = 1'b1;
        @(negedge clock);
        pix.rdReq = 1'b0;
        @(negedge clock);
        check({tag, "_early"}, pix.rdValid, 0);
        @(negedge clock);
        check({tag, "_valid"}, pix.rdValid, 1);
        check({tag, "_data"}, pix.rdData, model_rd(x, y));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        int xs[$];
        int ys[$];
        rgb565_t old;
        rgb565_t sprite [6];

        clearReq       = 1'b0;
        pix.xAddr      = '0;
        pix.yAddr      = '0;
        pix.pixelData  = '0;
        pix.pixelWrite = 1'b0;
        pix.rdReq      = 1'b0;
        pix.rdX        = '0;
        pix.rdY        = '0;

        // --- Reset release ---------------------------------------------
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", pix.pixelReady, 0);
        check("rst_count", pixelCount, 0);
        check("rst_clip", clipError, 0);
        check("rst_rdvalid", pix.rdValid, 0);
        check("rst_rddata", pix.rdData, 0);
        @(negedge clock);
        check("rst_ready_rise", pix.pixelReady, 1);

        // --- Single DrawMif-style write ---------------------------------
        draw(5, 10, 16'hF800, 0, low);
        check("w1_low", low, 4);
        check_rd("w1_rd", 5, 10);
        check("w1_count", pixelCount, exp_count);

        // --- Held pixelWrite yields one write --------------------------
        draw(0, 1, 16'h4321, 0, low);
        draw(6, 10, 16'h07E0, 10, low);
        check("hold_low", low, 4);
        check("hold_ready", pix.pixelReady, 1);
        check("hold_count", pixelCount, exp_count);
        check_rd("hold_rd", 6, 10);

        // --- Out-of-range pixel ------------------------------------------
        draw(240, 0, 16'h7777, 0, low);
        check("clip_low", low, 4);
        check("clip_flag", clipError, 1);
        check("clip_count", pixelCount, exp_count);
        check_rd("clip_alias", 0, 1);
        check_rd("rd_oor_x", 240, 0);
        check_rd("rd_oor_y", 0, 320);

        // --- Clear racing an accept --------------------------------------
        wait_ready("clr_wait");
        pix.xAddr      = 8'd7;
        pix.yAddr      = 9'd7;
        pix.pixelData  = 16'hABCD;
        pix.pixelWrite = 1'b1;
        clearReq       = 1'b1;
        @(negedge clock);
        clearReq       = 1'b0;
        pix.pixelWrite = 1'b0;
        low = 0;
        while (!pix.pixelReady && low < 100000) begin
            low++;
            @(negedge clock);
        end
        fb.delete();
        exp_count = 0;
        exp_clip  = 1'b0;
        check("clr_low", low, W * H);
        check("clr_count", pixelCount, exp_count);
        check("clr_clip", clipError, exp_clip);
        check_rd("clr_rd_pix", 7, 7);
        check_rd("clr_rd_a", 5, 10);
        check_rd("clr_rd_b", 0, 1);
        check_rd("clr_rd_first", 0, 0);
        check_rd("clr_rd_last", W - 1, H - 1);
        for (int i = 0; i < 6; i++) begin
            check_rd("clr_rd_rand", int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)));
        end

        // --- Random pixels, some clipped ---------------------------------
        for (int i = 0; i < 16; i++) begin
            int rx;
            int ry;
            rx = int'($urandom_range(0, 255));
            ry = int'($urandom_range(0, 339));
            draw(rx, ry, rgb565_t'($urandom), 0, low);
            check("rand_low", low, 4);
            xs.push_back(rx);
            ys.push_back(ry);
        end
        check("rand_count", pixelCount, exp_count);
        check("rand_clip", clipError, exp_clip);
        foreach (xs[i]) check_rd("rand_rd", xs[i], ys[i]);

        // --- Readback colliding with the RAM write returns old data ------
        wait_ready("col_wait");
        old = model_rd(50, 60);
        pix.xAddr      = 8'd50;
        pix.yAddr      = 9'd60;
        pix.pixelData  = 16'hBEEF;
        pix.pixelWrite = 1'b1;
        @(negedge clock);                 // accept edge k passed
        pix.pixelWrite = 1'b0;
        @(negedge clock);                 // k+1
        pix.rdX   = 8'd50;
        pix.rdY   = 9'd60;
        pix.rdReq = 1'b1;                 // sampled at k+2, RAM read at k+3
        @(negedge clock);
        pix.rdReq = 1'b0;
        @(negedge clock);
        @(negedge clock);                 // after k+4
        check("col_valid", pix.rdValid, 1);
        check("col_old", pix.rdData, old);
        model_write(50, 60, 16'hBEEF);
        check_rd("col_new", 50, 60);

        // --- 3x2 sprite at (100,200) with transparency -------------------
        draw(101, 200, 16'h1234, 0, low);
        draw(100, 201, 16'h5678, 0, low);
        sprite = '{16'hF800, 16'h0001, 16'h07E0, 16'h0001, 16'h001F, 16'hFFFF};
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (sprite[r * 3 + c] != 16'h0001) begin
                    draw(100 + c, 200 + r, sprite[r * 3 + c], 0, low);
                end
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                check_rd("sprite_rd", 100 + c, 200 + r);
            end
        end
        check("sprite_count", pixelCount, exp_count);

        // --- Reset during HOLD drops the pending write -------------------
        wait_ready("hrst_wait");
        old = model_rd(20, 30);
        pix.xAddr      = 8'd20;
        pix.yAddr      = 9'd30;
        pix.pixelData  = 16'h1111;
        pix.pixelWrite = 1'b1;
        @(negedge clock);                 // after k
        pix.pixelWrite = 1'b0;
        @(negedge clock);                 // after k+1
        @(negedge clock);                 // after k+2: HOLD, write pending
        reset = 1'b1;
        #1;
        check("hrst_ready0", pix.pixelReady, 0);
        @(negedge clock);
        check("hrst_ready1", pix.pixelReady, 0);
        reset = 1'b0;
        exp_count = 0;
        exp_clip  = 1'b0;
        #1;
        check("hrst_rel_ready", pix.pixelReady, 0);
        check("hrst_count", pixelCount, exp_count);
        check("hrst_clip", clipError, exp_clip);
        @(negedge clock);
        check("hrst_ready_rise", pix.pixelReady, 1);
        check_rd("hrst_rd", 20, 30);
        check("hrst_rd_old", pix.rdData, old);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
